// File: rtl/vertex_pkg.sv
// rtl/vertex_pkg.sv - shared state, slot-select encodings and key compare for vertex_buffer
package vertex_pkg;

  localparam int DEF_CW    = 3;
  localparam int DEF_NV    = 3;
  localparam int KEY_MAX_W = 32;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_NEW   = 2'd1,
    SEL_SHIFT = 2'd2,
    SEL_CLEAR = 2'd3
  } slot_sel_t;

  // Keys are {Y,X}, so a plain unsigned compare makes Y the major key.
  function automatic logic key_gt(input logic [KEY_MAX_W-1:0] a,
                                  input logic [KEY_MAX_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/vertex_slot.sv
// rtl/vertex_slot.sv - one {Y,X} vertex register with hold/load/shift/clear next-value mux
module vertex_slot
  import vertex_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  slot_sel_t    sel,
  input  logic [W-1:0] new_val,
  input  logic [W-1:0] below_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_NEW:   q <= new_val;
        SEL_SHIFT: q <= below_val;
        SEL_CLEAR: q <= '0;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/vertex_buffer.sv
// rtl/vertex_buffer.sv - NV-vertex frame store, LOAD/HOLD handshake; VERTEX_SORT_EN enables insertion sort by {Y,X}
module vertex_buffer
  import vertex_pkg::*;
#(
  parameter  int CW   = DEF_CW,
  parameter  int NV   = DEF_NV,
  localparam int KW   = 2 * CW,
  localparam int CNTW = $clog2(NV + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    Xi,
  input  logic [CW-1:0]    Yi,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NV*KW-1:0] P,
  output logic [CNTW-1:0]  count
);

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic [KW-1:0]   new_key;
  logic [KW-1:0]   slot_q [NV];
  logic [KW-1:0]   below  [NV];
  slot_sel_t       sel    [NV];
  logic            accept, consume;

  assign new_key   = {Yi, Xi};
  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = count;
    if (flush || consume) begin
      state_nxt = ST_LOAD;
      cnt_nxt   = '0;
    end else if (accept) begin
      cnt_nxt = count + 1'b1;
      if (count == CNTW'(NV - 1)) state_nxt = ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LOAD;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
    end
  end

`ifdef VERTEX_SORT_EN
  // gt[k]: occupied slot k sorts after the incoming vertex and must move up.
  logic [NV-1:0] gt;
  logic [NV-1:0] gt_below;

  always_comb begin
    gt = '0;
    for (int k = 0; k < NV; k++) begin
      gt[k] = (CNTW'(k) < count) &&
              key_gt(KEY_MAX_W'(slot_q[k]), KEY_MAX_W'(new_key));
    end
  end

  assign gt_below = {gt[NV-2:0], 1'b0};
`endif

  always_comb begin
    for (int k = 0; k < NV; k++) begin
      sel[k] = SEL_HOLD;
      if (flush || consume) begin
        sel[k] = SEL_CLEAR;
      end else if (accept) begin
`ifdef VERTEX_SORT_EN
        if (gt_below[k])                         sel[k] = SEL_SHIFT;
        else if (gt[k] || CNTW'(k) == count)     sel[k] = SEL_NEW;
`else
        if (CNTW'(k) == count)                   sel[k] = SEL_NEW;
`endif
      end
    end
  end

  for (genvar k = 0; k < NV; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign below[k] = '0;
    end else begin : g_rest
      assign below[k] = slot_q[k-1];
    end

    vertex_slot #(.W(KW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel[k]),
      .new_val   (new_key),
      .below_val (below[k]),
      .q         (slot_q[k])
    );

    assign P[k*KW +: KW] = slot_q[k];
  end

endmodule

// File: tb/tb_vertex_buffer.sv
// tb/tb_vertex_buffer.sv - randomized and directed checks of vertex_buffer against a queue-style model
module tb_vertex_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_iv, a_fl, a_ordy, a_ir, a_ov;
  logic [2:0]  a_x, a_y;
  logic [17:0] a_p;
  logic [1:0]  a_cnt;

  logic        b_iv, b_fl, b_ordy, b_ir, b_ov;
  logic [7:0]  b_x, b_y;
  logic [63:0] b_p;
  logic [2:0]  b_cnt;

  vertex_buffer #(.CW(3), .NV(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .Xi(a_x), .Yi(a_y),
    .flush(a_fl), .out_valid(a_ov), .out_ready(a_ordy), .P(a_p), .count(a_cnt)
  );

  vertex_buffer #(.CW(8), .NV(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .Xi(b_x), .Yi(b_y),
    .flush(b_fl), .out_valid(b_ov), .out_ready(b_ordy), .P(b_p), .count(b_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int unsigned mk [2][4];
  int          mn [2];
  bit          mhold [2];
  int          nv_of [2] = '{3, 4};
  int          cw_of [2] = '{3, 8};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      mn[d]    = 0;
      mhold[d] = 1'b0;
      for (int i = 0; i < 4; i++) mk[d][i] = 0;
    end
  endfunction

  function automatic void model_step(int d, bit iv, int x, int y, bit fl, bit ordy);
    int unsigned key;
    int pos;
    if (fl) begin
      mn[d] = 0;
      mhold[d] = 1'b0;
    end else if (mhold[d]) begin
      if (ordy) begin
        mn[d] = 0;
        mhold[d] = 1'b0;
      end
    end else if (iv) begin
      key = (int'(y) << cw_of[d]) | int'(x);
      pos = mn[d];
`ifdef VERTEX_SORT_EN
      for (int i = mn[d] - 1; i >= 0; i--) if (mk[d][i] > key) pos = i;
`endif
      for (int i = mn[d]; i > pos; i--) mk[d][i] = mk[d][i-1];
      mk[d][pos] = key;
      mn[d]++;
      if (mn[d] == nv_of[d]) mhold[d] = 1'b1;
    end
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d);
    logic [63:0] e;
    e = '0;
    for (int k = 0; k < mn[d]; k++) e |= 64'(mk[d][k]) << (k * 2 * cw_of[d]);
    if (d == 0) begin
      chk("a_count",     64'(a_cnt), 64'(mn[0]));
      chk("a_in_ready",  64'(a_ir),  64'(!mhold[0]));
      chk("a_out_valid", 64'(a_ov),  64'(mhold[0]));
      chk("a_P",         64'(a_p),   e);
    end else begin
      chk("b_count",     64'(b_cnt), 64'(mn[1]));
      chk("b_in_ready",  64'(b_ir),  64'(!mhold[1]));
      chk("b_out_valid", 64'(b_ov),  64'(mhold[1]));
      chk("b_P",         b_p,        e);
    end
  endtask

  task automatic idle();
    a_iv = 0; a_fl = 0; a_ordy = 0; a_x = '0; a_y = '0;
    b_iv = 0; b_fl = 0; b_ordy = 0; b_x = '0; b_y = '0;
  endtask

  task automatic step(int d, bit iv, int x, int y, bit fl, bit ordy);
    idle();
    if (d == 0) begin
      a_iv = iv; a_x = x[2:0]; a_y = y[2:0]; a_fl = fl; a_ordy = ordy;
    end else begin
      b_iv = iv; b_x = x[7:0]; b_y = y[7:0]; b_fl = fl; b_ordy = ordy;
    end
    @(posedge clk);
    model_step(d, iv, x, y, fl, ordy);
    #1;
    check_dut(d);
  endtask

  initial begin
    int d, cw;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    rst = 1'b1;

    // Reset mid-load takes effect without a clock edge
    step(0, 1, 1, 2, 0, 0);
    step(0, 1, 3, 4, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_dut(0);
    #1 rst = 1'b1;

    // Back-to-back load of a full frame
    step(0, 1, 1, 5, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 7, 3, 0, 0);
`ifdef VERTEX_SORT_EN
    chk("frame_sorted", 64'(a_p), 64'({3'd5, 3'd1, 3'd3, 3'd7, 3'd0, 3'd2}));
`else
    chk("frame_arrival", 64'(a_p), 64'({3'd3, 3'd7, 3'd0, 3'd2, 3'd5, 3'd1}));
`endif

    // in_valid held through HOLD and the consume cycle is ignored
    step(0, 1, 6, 6, 0, 0);
    step(0, 1, 6, 6, 0, 0);
    step(0, 1, 6, 6, 0, 1);
    step(0, 1, 4, 1, 0, 0);
    chk("after_consume_slot0", 64'(a_p), 64'({3'd1, 3'd4}));

    // X minor-key tie
    step(0, 1, 4, 2, 0, 0);
    step(0, 1, 1, 2, 0, 0);
`ifdef VERTEX_SORT_EN
    chk("tie_sorted", 64'(a_p), 64'({3'd2, 3'd4, 3'd2, 3'd1, 3'd1, 3'd4}));
`else
    chk("tie_arrival", 64'(a_p), 64'({3'd2, 3'd1, 3'd2, 3'd4, 3'd1, 3'd4}));
`endif

    // Flush beats simultaneous in_valid and out_ready in HOLD, and a partial load
    step(0, 1, 5, 5, 1, 1);
    step(0, 1, 3, 3, 0, 0);
    step(0, 1, 2, 2, 1, 0);

    // Wide coordinates, NV=4 with exact duplicates
    step(1, 1, 255, 255, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 200, 10, 0, 0);
    step(1, 1, 255, 255, 0, 0);
    step(1, 0, 0, 0, 0, 1);

    repeat (400) begin
      d  = int'($urandom_range(0, 1));
      cw = cw_of[d];
      step(d, $urandom_range(0, 9) < 7, int'($urandom_range(0, (1 << cw) - 1)),
           int'($urandom_range(0, (1 << cw) - 1)), $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
